axi_burst_master: RTL and testbench

//  Next-generation CPU-side AXI4 master bridging the CPU's SRAM-style port (CEB/WEB/BWEB) to the bus.

---
 rtl/axi_master_pkg.sv | 26 ++
 rtl/axi_beat_cnt.sv | 28 ++
 rtl/axi_burst_master.sv | 234 +++++++++++++++++++++++
 tb/tb_axi_burst_master.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_master_pkg.sv
// Shared types and constants for the CPU-side AXI4 burst master.
package axi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RADDR,
        ST_RDATA,
        ST_WRITE,
        ST_WRESP,
        ST_DONE
    } state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // AxSIZE encoding for a full-width beat: log2(data_w / 8).
    function automatic logic [2:0] size_of(input int unsigned data_w);
        logic [2:0] s;
        s = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if ((32'd8 << i) == data_w) s = 3'(i);
        end
        return s;
    endfunction

endpackage

// File: rtl/axi_beat_cnt.sv
// 4-bit beat counter: clears on load, advances per handshake, flags the final beat.
module axi_beat_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       incr_i,
    input  logic [3:0] len_i,
    output logic [3:0] cnt_o,
    output logic       last_o
);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)      cnt_d = '0;
        else if (incr_i) cnt_d = cnt_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == len_i);

endmodule

// File: rtl/axi_burst_master.sv
// CPU SRAM-style port (CEB/WEB/BWEB) to AXI4 master with INCR bursts, one transaction outstanding.
// Optional macro AXI_MASTER_ERR_EN enables the sticky response/beat-count error flag.
module axi_burst_master
    import axi_master_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ID_W     = 4,
    parameter int unsigned ID_VAL   = 0,
    parameter int unsigned MAX_LEN  = 16,
    parameter int unsigned WRITE_EN = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  CEB,
    input  logic                  WEB,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W/8-1:0]   bweb,
    input  logic [DATA_W-1:0]     writeData,
    input  logic [3:0]            burst_len,
    output logic [DATA_W-1:0]     readData,
    output logic                  rbeat,
    output logic                  wnext,
    output logic                  busBusy,
    output logic                  err,
    input  logic                  err_clr,
    output logic [ID_W-1:0]       ARID,
    output logic [ADDR_W-1:0]     ARADDR,
    output logic [7:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic [1:0]            ARBURST,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [ID_W-1:0]       RID,
    input  logic [DATA_W-1:0]     RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY,
    output logic [ID_W-1:0]       AWID,
    output logic [ADDR_W-1:0]     AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic [1:0]            AWBURST,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_W-1:0]     WDATA,
    output logic [DATA_W/8-1:0]   WSTRB,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [ID_W-1:0]       BID,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY
);

    localparam logic       WEN     = (WRITE_EN != 0);
    localparam logic [3:0] LEN_CAP = 4'(MAX_LEN - 1);
    localparam logic [2:0] SIZE    = size_of(DATA_W);

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [3:0]            len_q, len_d;
    logic [DATA_W/8-1:0]   bweb_q, bweb_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  rbeat_q;
    logic                  cnt_load;
    logic                  r_hs, w_hs, aw_hs, b_hs;
    logic                  r_last, w_last, r_mismatch;
    logic [3:0]            r_cnt, w_cnt;
    logic [3:0]            len_in;

    assign len_in = (burst_len > LEN_CAP) ? LEN_CAP : burst_len;

    assign r_hs  = RVALID & RREADY;
    assign w_hs  = WVALID & WREADY;
    assign aw_hs = AWVALID & AWREADY;
    assign b_hs  = BVALID & BREADY;
    // An early RLAST (before the counted last beat) or a late one both end up here.
    assign r_mismatch = r_hs & (RLAST != r_last);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        bweb_d    = bweb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        cnt_load  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!CEB) begin
                    addr_d    = addr;
                    len_d     = len_in;
                    bweb_d    = bweb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    cnt_load  = 1'b1;
                    // An ignored write still passes through DONE so the CPU is not stalled.
                    if (WEB)      state_d = ST_RADDR;
                    else if (WEN) state_d = ST_WRITE;
                    else          state_d = ST_DONE;
                end
            end
            ST_RADDR: if (ARREADY) state_d = ST_RDATA;
            ST_RDATA: if (r_hs && RLAST) state_d = ST_DONE;
            ST_WRITE: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | (w_hs & WLAST);
                if (aw_done_d && w_done_d) state_d = ST_WRESP;
            end
            ST_WRESP: if (BVALID) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (r_hs) rdata_d = RDATA;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            bweb_q    <= '1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            rbeat_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            bweb_q    <= bweb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            rbeat_q   <= r_hs;
        end
    end

    axi_beat_cnt u_rcnt (
        .clk   (clk),
        .rst   (rst),
        .load_i(cnt_load),
        .incr_i(r_hs),
        .len_i (len_q),
        .cnt_o (r_cnt),
        .last_o(r_last)
    );

    axi_beat_cnt u_wcnt (
        .clk   (clk),
        .rst   (rst),
        .load_i(cnt_load),
        .incr_i(w_hs),
        .len_i (len_q),
        .cnt_o (w_cnt),
        .last_o(w_last)
    );

    assign ARID    = ID_W'(ID_VAL);
    assign ARADDR  = addr_q;
    assign ARLEN   = {4'b0000, len_q};
    assign ARSIZE  = SIZE;
    assign ARBURST = BURST_INCR;
    assign ARVALID = (state_q == ST_RADDR);
    assign RREADY  = (state_q == ST_RDATA);

    assign AWID    = WEN ? ID_W'(ID_VAL) : '0;
    assign AWADDR  = WEN ? addr_q : '0;
    assign AWLEN   = WEN ? {4'b0000, len_q} : '0;
    assign AWSIZE  = WEN ? SIZE : '0;
    assign AWBURST = WEN ? BURST_INCR : '0;
    assign AWVALID = WEN & (state_q == ST_WRITE) & ~aw_done_q;
    assign WDATA   = WEN ? writeData : '0;
    assign WSTRB   = WEN ? ~bweb_q : '0;
    assign WLAST   = WEN & w_last;
    assign WVALID  = WEN & (state_q == ST_WRITE) & ~w_done_q;
    assign BREADY  = WEN & (state_q == ST_WRESP);

    assign readData = rdata_q;
    assign rbeat    = rbeat_q;
    assign wnext    = w_hs;
    assign busBusy  = ((state_q == ST_IDLE) & ~CEB) |
                      ((state_q != ST_IDLE) & (state_q != ST_DONE));

`ifdef AXI_MASTER_ERR_EN
    logic err_q, err_d, err_set;

    assign err_set = (r_hs & ((RRESP != RESP_OKAY) | r_mismatch)) |
                     (b_hs & (BRESP != RESP_OKAY));

    always_comb begin
        err_d = err_q;
        if (err_set)      err_d = 1'b1;
        else if (err_clr) err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_d;
    end

    assign err = err_q;

    logic unused_ok;
    assign unused_ok = ^{RID, BID, r_cnt, w_cnt};
`else
    assign err = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{RID, BID, r_cnt, w_cnt, RRESP, BRESP, err_clr, r_mismatch};
`endif

`ifndef SYNTHESIS
    logic [ADDR_W-1:0] burst_end;
    assign burst_end = addr_q + ADDR_W'(len_q) * ADDR_W'(DATA_W / 8);

    always_ff @(posedge clk) begin
        if (rst && (ARVALID || AWVALID)) begin
            assert (burst_end[ADDR_W-1:12] == addr_q[ADDR_W-1:12])
                else $error("axi_burst_master: burst crosses a 4KB boundary");
        end
    end
`endif

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master; a second instance with MAX_LEN=4 covers length clamping.
module tb_axi_burst_master;

`ifdef AXI_MASTER_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        CEB = 1'b1, WEB = 1'b1, err_clr = 1'b0;
    logic [31:0] addr = '0, writeData = '0;
    logic [3:0]  bweb = 4'hF, burst_len = '0;
    logic        ARREADY = 1'b0, RLAST = 1'b0, RVALID = 1'b0;
    logic        AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0;
    logic [3:0]  RID = '0, BID = '0;
    logic [31:0] RDATA = '0;
    logic [1:0]  RRESP = '0, BRESP = '0;

    logic [31:0] readData, ARADDR, AWADDR, WDATA;
    logic        rbeat, wnext, busBusy, err, ARVALID, RREADY, AWVALID, WLAST, WVALID, BREADY;
    logic [3:0]  ARID, AWID, WSTRB;
    logic [7:0]  ARLEN, AWLEN;
    logic [2:0]  ARSIZE, AWSIZE;
    logic [1:0]  ARBURST, AWBURST;

    logic [31:0] readData_b, ARADDR_b, AWADDR_b, WDATA_b;
    logic        rbeat_b, wnext_b, busBusy_b, err_b, ARVALID_b, RREADY_b, AWVALID_b, WLAST_b, WVALID_b, BREADY_b;
    logic [3:0]  ARID_b, AWID_b, WSTRB_b;
    logic [7:0]  ARLEN_b, AWLEN_b;
    logic [2:0]  ARSIZE_b, AWSIZE_b;
    logic [1:0]  ARBURST_b, AWBURST_b;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    axi_burst_master #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .ID_VAL(0), .MAX_LEN(16), .WRITE_EN(1)) u_dut (
        .clk(clk), .rst(rst), .CEB(CEB), .WEB(WEB), .addr(addr), .bweb(bweb), .writeData(writeData),
        .burst_len(burst_len), .readData(readData), .rbeat(rbeat), .wnext(wnext), .busBusy(busBusy),
        .err(err), .err_clr(err_clr),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    axi_burst_master #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .ID_VAL(0), .MAX_LEN(4), .WRITE_EN(1)) u_dut_b (
        .clk(clk), .rst(rst), .CEB(CEB), .WEB(WEB), .addr(addr), .bweb(bweb), .writeData(writeData),
        .burst_len(burst_len), .readData(readData_b), .rbeat(rbeat_b), .wnext(wnext_b), .busBusy(busBusy_b),
        .err(err_b), .err_clr(err_clr),
        .ARID(ARID_b), .ARADDR(ARADDR_b), .ARLEN(ARLEN_b), .ARSIZE(ARSIZE_b), .ARBURST(ARBURST_b),
        .ARVALID(ARVALID_b), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY_b),
        .AWID(AWID_b), .AWADDR(AWADDR_b), .AWLEN(AWLEN_b), .AWSIZE(AWSIZE_b), .AWBURST(AWBURST_b),
        .AWVALID(AWVALID_b), .AWREADY(AWREADY),
        .WDATA(WDATA_b), .WSTRB(WSTRB_b), .WLAST(WLAST_b), .WVALID(WVALID_b), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #1;
    endtask

    int unsigned beats;

    initial begin
        // Reset state
        step(); step();
        check("rst_arvalid", 64'(ARVALID), 64'h0);
        check("rst_rready", 64'(RREADY), 64'h0);
        check("rst_awvalid", 64'(AWVALID), 64'h0);
        check("rst_wvalid", 64'(WVALID), 64'h0);
        check("rst_bready", 64'(BREADY), 64'h0);
        check("rst_readdata", 64'(readData), 64'h0);
        check("rst_rbeat", 64'(rbeat), 64'h0);
        check("rst_err", 64'(err), 64'h0);
        check("rst_busy", 64'(busBusy), 64'h0);
        rst = 1'b1;

        // 1: single read, zero-wait slave
        step();
        CEB = 1'b0; WEB = 1'b1; addr = 32'h100; burst_len = 4'd0;
        settle();
        check("t1_busy_req", 64'(busBusy), 64'h1);
        step();
        CEB = 1'b1; ARREADY = 1'b1;
        settle();
        check("t1_arvalid", 64'(ARVALID), 64'h1);
        check("t1_arlen", 64'(ARLEN), 64'h0);
        check("t1_araddr", 64'(ARADDR), 64'h100);
        check("t1_arsize", 64'(ARSIZE), 64'h2);
        check("t1_arburst", 64'(ARBURST), 64'h1);
        check("t1_busy_raddr", 64'(busBusy), 64'h1);
        step();
        ARREADY = 1'b0; RVALID = 1'b1; RDATA = 32'hDEADBEEF; RLAST = 1'b1;
        settle();
        check("t1_rready", 64'(RREADY), 64'h1);
        check("t1_busy_rdata", 64'(busBusy), 64'h1);
        step();
        RVALID = 1'b0; RLAST = 1'b0;
        settle();
        check("t1_busy_done", 64'(busBusy), 64'h0);
        check("t1_rbeat", 64'(rbeat), 64'h1);
        check("t1_readdata", 64'(readData), 64'hDEADBEEF);
        step();
        settle();
        check("t1_rbeat_end", 64'(rbeat), 64'h0);
        check("t1_readdata_hold", 64'(readData), 64'hDEADBEEF);

        // 2: read burst len=3 with a gap before every beat
        step();
        CEB = 1'b0; WEB = 1'b1; addr = 32'h200; burst_len = 4'd3;
        step();
        CEB = 1'b1; ARREADY = 1'b1;
        settle();
        check("t2_arlen", 64'(ARLEN), 64'h3);
        step();
        ARREADY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            RVALID = 1'b1; RDATA = 32'hCAFE0000 | 32'(i); RLAST = (i == 3);
            settle();
            check("t2_rbeat_gap", 64'(rbeat), 64'h0);
            check("t2_busy", 64'(busBusy), 64'h1);
            step();
            RVALID = 1'b0; RLAST = 1'b0;
            settle();
            check("t2_rbeat", 64'(rbeat), 64'h1);
            check("t2_readdata", 64'(readData), 64'(32'hCAFE0000 | 32'(i)));
        end
        check("t2_done_busy", 64'(busBusy), 64'h0);
        check("t2_err", 64'(err), 64'h0);
        step();

        // 3: write burst len=1, AWREADY held off for 4 cycles
        step();
        CEB = 1'b0; WEB = 1'b0; addr = 32'h300; burst_len = 4'd1; bweb = 4'b0011;
        writeData = 32'h11111111; WREADY = 1'b1; AWREADY = 1'b0;
        step();
        CEB = 1'b1;
        settle();
        check("t3_awvalid_w1", 64'(AWVALID), 64'h1);
        check("t3_wvalid_w1", 64'(WVALID), 64'h1);
        check("t3_wstrb", 64'(WSTRB), 64'hC);
        check("t3_wlast_b0", 64'(WLAST), 64'h0);
        check("t3_wdata_b0", 64'(WDATA), 64'h11111111);
        check("t3_wnext_b0", 64'(wnext), 64'h1);
        check("t3_awlen", 64'(AWLEN), 64'h1);
        check("t3_awaddr", 64'(AWADDR), 64'h300);
        step();
        writeData = 32'h22222222;
        settle();
        check("t3_wlast_b1", 64'(WLAST), 64'h1);
        check("t3_wdata_b1", 64'(WDATA), 64'h22222222);
        check("t3_wnext_b1", 64'(wnext), 64'h1);
        step();
        settle();
        check("t3_wvalid_off", 64'(WVALID), 64'h0);
        check("t3_wnext_off", 64'(wnext), 64'h0);
        check("t3_awvalid_w3", 64'(AWVALID), 64'h1);
        check("t3_busy_w3", 64'(busBusy), 64'h1);
        step();
        settle();
        check("t3_bready_early", 64'(BREADY), 64'h0);
        check("t3_awvalid_w4", 64'(AWVALID), 64'h1);
        step();
        AWREADY = 1'b1;
        settle();
        check("t3_bready_w5", 64'(BREADY), 64'h0);
        step();
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b1; BRESP = 2'b00;
        settle();
        check("t3_bready", 64'(BREADY), 64'h1);
        check("t3_awvalid_off", 64'(AWVALID), 64'h0);
        step();
        BVALID = 1'b0;
        settle();
        check("t3_done_busy", 64'(busBusy), 64'h0);
        check("t3_done_bready", 64'(BREADY), 64'h0);
        step();
        bweb = 4'hF;

        // 4: burst_len=15 against MAX_LEN=4 (u_dut_b) and MAX_LEN=16 (u_dut)
        step();
        CEB = 1'b0; WEB = 1'b1; addr = 32'h400; burst_len = 4'd15;
        step();
        CEB = 1'b1; ARREADY = 1'b1;
        settle();
        check("t4_arlen_clamp", 64'(ARLEN_b), 64'h3);
        check("t4_arlen_full", 64'(ARLEN), 64'hF);
        step();
        ARREADY = 1'b0;
        beats = 0;
        for (int i = 0; i < 4; i++) begin
            RVALID = 1'b1; RDATA = 32'h44440000 | 32'(i); RLAST = (i == 3);
            step();
            settle();
            if (rbeat_b) beats++;
        end
        RVALID = 1'b0; RLAST = 1'b0;
        check("t4_done_busy", 64'(busBusy_b), 64'h0);
        check("t4_readdata", 64'(readData_b), 64'h44440003);
        check("t4_err_clamped", 64'(err_b), 64'h0);
        check("t4_err_mismatch", 64'(err), 64'(ERR_ON));
        step();
        settle();
        if (rbeat_b) beats++;
        check("t4_beats", 64'(beats), 64'd4);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        settle();
        check("t4_err_cleared", 64'(err), 64'h0);

        // 5: asynchronous reset in the middle of a read burst
        step();
        CEB = 1'b0; WEB = 1'b1; addr = 32'h500; burst_len = 4'd2;
        step();
        CEB = 1'b1; ARREADY = 1'b1;
        step();
        ARREADY = 1'b0; RVALID = 1'b1; RDATA = 32'h55AA55AA; RLAST = 1'b0;
        step();
        RVALID = 1'b0;
        settle();
        check("t5_readdata_pre", 64'(readData), 64'h55AA55AA);
        check("t5_rready_pre", 64'(RREADY), 64'h1);
        rst = 1'b0;
        settle();
        check("t5_rready", 64'(RREADY), 64'h0);
        check("t5_arvalid", 64'(ARVALID), 64'h0);
        check("t5_readdata", 64'(readData), 64'h0);
        check("t5_rbeat", 64'(rbeat), 64'h0);
        check("t5_busy", 64'(busBusy), 64'h0);
        #2;
        rst = 1'b1;
        step();
        settle();
        check("t5_idle_rready", 64'(RREADY), 64'h0);
        check("t5_idle_busy", 64'(busBusy), 64'h0);

        // 6: SLVERR write response, sticky err then err_clr
        step();
        CEB = 1'b0; WEB = 1'b0; addr = 32'h600; burst_len = 4'd0; bweb = 4'h0;
        writeData = 32'h66666666; AWREADY = 1'b1; WREADY = 1'b1;
        step();
        CEB = 1'b1;
        settle();
        check("t6_wlast", 64'(WLAST), 64'h1);
        check("t6_wstrb", 64'(WSTRB), 64'hF);
        step();
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b1; BRESP = 2'b10;
        settle();
        check("t6_bready", 64'(BREADY), 64'h1);
        check("t6_err_before", 64'(err), 64'h0);
        step();
        BVALID = 1'b0; BRESP = 2'b00;
        settle();
        check("t6_err_set", 64'(err), 64'(ERR_ON));
        step(); step();
        settle();
        check("t6_err_sticky", 64'(err), 64'(ERR_ON));
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        settle();
        check("t6_err_clr", 64'(err), 64'h0);
        bweb = 4'hF;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
